// File: rtl/ffs_pkg.sv
// Shared types and helpers for the streaming set-bit enumerator.
package ffs_pkg;

  // Scanner FSM states: waiting for a vector, or emitting its indices.
  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } ffs_state_e;

  // Index reported for an empty vector; callers slice it to their index width.
  localparam logic [31:0] NONE_IDX_ALL = '1;

  // Width of a bit index for an n-bit vector (never narrower than one bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ffs_scanner_if.sv
// Vector-in / index-out stream bundle for ffs_scanner.
//
// Handshake: an input vector transfers on a cycle where i_valid && o_ready; an
// output beat transfers on a cycle where o_valid && i_ready. A driver holds
// valid and its payload stable until the transfer. o_ready may depend
// combinationally on i_ready, which allows a new vector to be taken in the same
// cycle that the last beat of the previous one is delivered.
interface ffs_scanner_if
  import ffs_pkg::*;
#(
  parameter int N_CANDIDATES = 8
);
  localparam int W = idx_width(N_CANDIDATES);

  logic                    i_valid;
  logic                    o_ready;
  logic [N_CANDIDATES-1:0] i_data;
  logic                    i_flush;
  logic                    o_valid;
  logic                    i_ready;
  logic [W-1:0]            o_data;
  logic                    o_last;
  logic                    o_empty;

  // Producer/consumer side.
  modport master (
    output i_valid, i_data, i_flush, i_ready,
    input  o_ready, o_valid, o_data, o_last, o_empty
  );

  // Scanner side.
  modport slave (
    input  i_valid, i_data, i_flush, i_ready,
    output o_ready, o_valid, o_data, o_last, o_empty
  );

endinterface

// File: rtl/ffs_priority.sv
// Combinational find-first-set tree: lowest index with its bit set wins.
// Index 0 is the MSB when MSB_FIRST=1, the LSB otherwise.
module ffs_priority
  import ffs_pkg::*;
#(
  parameter int N_CANDIDATES = 8,
  parameter bit MSB_FIRST    = 1'b1,
  localparam int W           = idx_width(N_CANDIDATES)
) (
  input  logic [N_CANDIDATES-1:0] req_i,
  output logic [W-1:0]            idx_o,
  output logic                    found_o
);

  // Heap-ordered tree: node n has children 2n (lower indices) and 2n+1.
  // Leaves N..2N-1 hold index 0..N-1; each node carries an absolute index.
  logic [2*N_CANDIDATES-1:1] node_found;
  logic [W-1:0]              node_idx [2*N_CANDIDATES-1:1];

  // Leaves: map vector bits into index order.
  for (genvar j = 0; j < N_CANDIDATES; j++) begin : g_leaf
    localparam int BIT = MSB_FIRST ? (N_CANDIDATES - 1 - j) : j;
    assign node_found[N_CANDIDATES+j] = req_i[BIT];
    assign node_idx[N_CANDIDATES+j]   = W'(j);
  end

  // Internal nodes: prefer the lower-index subtree.
  for (genvar n = 1; n < N_CANDIDATES; n++) begin : g_node
    assign node_found[n] = node_found[2*n] | node_found[2*n+1];
    assign node_idx[n]   = node_found[2*n] ? node_idx[2*n] : node_idx[2*n+1];
  end

  assign idx_o   = node_idx[1];
  assign found_o = node_found[1];

endmodule

// File: rtl/ffs_scanner.sv
// Streaming set-bit enumerator: takes a vector, emits the index of every set
// bit, one beat per cycle in ascending index order, or a single empty beat.
module ffs_scanner
  import ffs_pkg::*;
#(
  parameter int N_CANDIDATES = 8,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  ffs_scanner_if.slave bus
);

  localparam int W = idx_width(N_CANDIDATES);

  if (N_CANDIDATES < 2 || (N_CANDIDATES & (N_CANDIDATES - 1)) != 0) begin : g_bad_width
    $fatal(1, "ffs_scanner: N_CANDIDATES must be a power of 2 and at least 2");
  end

  ffs_state_e              state_q;
  logic [N_CANDIDATES-1:0] remaining_q;
  logic                    empty_q;

  logic [W-1:0]            idx;
  logic                    found;
  logic [N_CANDIDATES-1:0] clear_mask;
  logic [N_CANDIDATES-1:0] remaining_d;
  logic                    scan_last;
  logic                    beat;
  logic                    accept;

  ffs_priority #(
    .N_CANDIDATES(N_CANDIDATES),
    .MSB_FIRST   (MSB_FIRST)
  ) u_priority (
    .req_i  (remaining_q),
    .idx_o  (idx),
    .found_o(found)
  );

  // Decode the winning index back to its vector bit and strip it.
  always_comb begin
    clear_mask = '0;
    for (int b = 0; b < N_CANDIDATES; b++) begin
      clear_mask[b] = (W'(MSB_FIRST ? (N_CANDIDATES - 1 - b) : b) == idx);
    end
    remaining_d = remaining_q & ~clear_mask;
  end

  assign scan_last = empty_q || (remaining_d == '0);
  assign beat      = bus.o_valid && bus.i_ready;
  assign accept    = bus.i_valid && bus.o_ready;

  // Outputs are forced to zero whenever no beat is presented.
  assign bus.o_valid = (state_q == SCAN);
  assign bus.o_empty = bus.o_valid && empty_q;
  assign bus.o_last  = bus.o_valid && scan_last;
  assign bus.o_data  = !bus.o_valid ? '0 :
                       (empty_q || !found) ? NONE_IDX_ALL[W-1:0] : idx;
  // Ready in IDLE, or as the last beat leaves (no bubble); never while
  // flushing or in reset.
  assign bus.o_ready = !rst && ((state_q == IDLE) ||
                                (beat && scan_last && !bus.i_flush));

  // Scanner FSM with its remaining-bits and empty-vector registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      empty_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= SCAN;
            remaining_q <= bus.i_data;
            empty_q     <= (bus.i_data == '0);
          end
        end
        SCAN: begin
          if (bus.i_flush) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            empty_q     <= 1'b0;
          end else if (beat) begin
            if (!scan_last) begin
              remaining_q <= remaining_d;
            end else if (accept) begin
              remaining_q <= bus.i_data;
              empty_q     <= (bus.i_data == '0);
            end else begin
              state_q     <= IDLE;
              remaining_q <= '0;
              empty_q     <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ffs_scanner.sv
// Bench for ffs_scanner: three configurations, directed vectors, expected
// beats queued by the stimulus and consumed by per-instance monitors.
module tb_ffs_scanner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // Beat word: {empty, last, index[3:0]}.
  logic [5:0] exp_q_a[$];
  logic [5:0] exp_q_b[$];
  logic [5:0] exp_q_c[$];

  ffs_scanner_if #(.N_CANDIDATES(8))  a_if ();
  ffs_scanner_if #(.N_CANDIDATES(8))  b_if ();
  ffs_scanner_if #(.N_CANDIDATES(16)) c_if ();

  ffs_scanner #(.N_CANDIDATES(8),  .MSB_FIRST(1'b1)) u_a (.clk(clk), .rst(rst), .bus(a_if));
  ffs_scanner #(.N_CANDIDATES(8),  .MSB_FIRST(1'b0)) u_b (.clk(clk), .rst(rst), .bus(b_if));
  ffs_scanner #(.N_CANDIDATES(16), .MSB_FIRST(1'b1)) u_c (.clk(clk), .rst(rst), .bus(c_if));

  function automatic logic [5:0] beat_w(input int d, input logic l, input logic e);
    logic [3:0] d4;
    d4 = d[3:0];
    return {e, l, d4};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [5:0] got);
    n_checks++;
    n_errors++;
    $display("FAIL %s: unexpected beat %0h (t=%0t)", name, got, $time);
  endtask

  // ---------------- monitors ----------------
  logic       hold_a = 1'b0;
  logic [5:0] hold_word_a = '0;

  always @(negedge clk) begin
    logic [5:0] got;
    got = {a_if.o_empty, a_if.o_last, 1'b0, a_if.o_data};
    if (a_if.o_valid) begin
      if (hold_a) check("a_stall_hold", got, hold_word_a);
      if (a_if.i_ready) begin
        if (exp_q_a.size() == 0) unexpected("a_beat", got);
        else check("a_beat", got, exp_q_a.pop_front());
        hold_a = 1'b0;
      end else begin
        hold_a      = 1'b1;
        hold_word_a = got;
      end
    end else begin
      hold_a = 1'b0;
      check("a_idle_zero", got, 16'd0);
    end
  end

  always @(negedge clk) begin
    logic [5:0] got;
    got = {b_if.o_empty, b_if.o_last, 1'b0, b_if.o_data};
    if (b_if.o_valid && b_if.i_ready) begin
      if (exp_q_b.size() == 0) unexpected("b_beat", got);
      else check("b_beat", got, exp_q_b.pop_front());
    end
  end

  always @(negedge clk) begin
    logic [5:0] got;
    got = {c_if.o_empty, c_if.o_last, c_if.o_data};
    if (c_if.o_valid && c_if.i_ready) begin
      if (exp_q_c.size() == 0) unexpected("c_beat", got);
      else check("c_beat", got, exp_q_c.pop_front());
    end
  end

  // ---------------- drivers ----------------
  // Present a vector until accepted; returns the number of cycles waited.
  task automatic send_a(input logic [7:0] v, output int waits);
    logic got;
    got = 1'b0;
    waits = 0;
    a_if.i_valid = 1'b1;
    a_if.i_data  = v;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      waits++;
      if (a_if.o_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL a_accept_timeout: o_ready never rose for %0h", v);
    end
    @(posedge clk);
    #1;
    a_if.i_valid = 1'b0;
    a_if.i_data  = 8'($urandom);
  endtask

  task automatic send_b(input logic [7:0] v);
    logic got;
    got = 1'b0;
    b_if.i_valid = 1'b1;
    b_if.i_data  = v;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (b_if.o_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL b_accept_timeout: o_ready never rose");
    end
    @(posedge clk);
    #1;
    b_if.i_valid = 1'b0;
    b_if.i_data  = 8'($urandom);
  endtask

  task automatic send_c(input logic [15:0] v);
    logic got;
    got = 1'b0;
    c_if.i_valid = 1'b1;
    c_if.i_data  = v;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (c_if.o_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL c_accept_timeout: o_ready never rose");
    end
    @(posedge clk);
    #1;
    c_if.i_valid = 1'b0;
    c_if.i_data  = 16'($urandom);
  endtask

  // Wait until every expected beat was seen and all scanners are idle.
  task automatic wait_drain(input string name);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (exp_q_a.size() == 0 && exp_q_b.size() == 0 && exp_q_c.size() == 0 &&
          !a_if.o_valid && !b_if.o_valid && !c_if.o_valid) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_drain_timeout: queues a=%0d b=%0d c=%0d", name,
               exp_q_a.size(), exp_q_b.size(), exp_q_c.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int waits;
    a_if.i_valid = 1'b0; a_if.i_data = '0; a_if.i_flush = 1'b0; a_if.i_ready = 1'b1;
    b_if.i_valid = 1'b0; b_if.i_data = '0; b_if.i_flush = 1'b0; b_if.i_ready = 1'b1;
    c_if.i_valid = 1'b0; c_if.i_data = '0; c_if.i_flush = 1'b0; c_if.i_ready = 1'b1;

    // Reset state.
    #2;
    check("rst_o_valid", a_if.o_valid, 0);
    check("rst_o_data",  a_if.o_data,  0);
    check("rst_o_last",  a_if.o_last,  0);
    check("rst_o_empty", a_if.o_empty, 0);
    check("rst_o_ready", a_if.o_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready_a", a_if.o_ready, 1);
    check("post_rst_ready_c", c_if.o_ready, 1);
    @(posedge clk);
    #1;

    // MSB-first 1010_0001: indices 0, 2, 7.
    exp_q_a.push_back(beat_w(0, 0, 0));
    exp_q_a.push_back(beat_w(2, 0, 0));
    exp_q_a.push_back(beat_w(7, 1, 0));
    send_a(8'b1010_0001, waits);
    @(negedge clk);
    check("latency_first_beat", a_if.o_valid, 1);
    wait_drain("msb_a1");

    // Empty vector: single beat 7/last/empty, ready in that cycle.
    exp_q_a.push_back(beat_w(7, 1, 1));
    send_a(8'h00, waits);
    @(negedge clk);
    check("empty_ready", {a_if.o_valid, a_if.o_ready}, 2'b11);
    wait_drain("empty");

    // Back-pressure on 0xFF with i_ready pattern 1,0,0,1,0,0...
    for (int i = 0; i < 8; i++) exp_q_a.push_back(beat_w(i, (i == 7), 0));
    send_a(8'hFF, waits);
    for (int k = 0; k < 60; k++) begin
      a_if.i_ready = (k % 3 == 0);
      @(posedge clk);
      #1;
      if (exp_q_a.size() == 0) break;
    end
    a_if.i_ready = 1'b1;
    wait_drain("backpressure");

    // Back-to-back 0x81 then 0x40: 0, 7(last), 1(last) with no bubble.
    exp_q_a.push_back(beat_w(0, 0, 0));
    exp_q_a.push_back(beat_w(7, 1, 0));
    exp_q_a.push_back(beat_w(1, 1, 0));
    send_a(8'h81, waits);
    send_a(8'h40, waits);
    check("b2b_accept_cycle", waits, 2);
    @(negedge clk);
    check("b2b_no_bubble", a_if.o_valid, 1);
    wait_drain("b2b");

    // Flush after the first beat of 0xF0.
    exp_q_a.push_back(beat_w(0, 0, 0));
    send_a(8'hF0, waits);
    @(posedge clk);
    #1;
    a_if.i_flush = 1'b1;
    a_if.i_ready = 1'b0;
    @(negedge clk);
    check("flush_cycle_ready", a_if.o_ready, 0);
    @(posedge clk);
    #1;
    a_if.i_flush = 1'b0;
    a_if.i_ready = 1'b1;
    @(negedge clk);
    check("flush_after_valid", a_if.o_valid, 0);
    check("flush_after_ready", a_if.o_ready, 1);
    wait_drain("flush");

    // Reset in the middle of a 0xFF scan.
    exp_q_a.push_back(beat_w(0, 0, 0));
    exp_q_a.push_back(beat_w(1, 0, 0));
    send_a(8'hFF, waits);
    @(posedge clk);
    #1;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_o_valid", a_if.o_valid, 0);
    check("midrst_o_data",  a_if.o_data,  0);
    check("midrst_o_last",  a_if.o_last,  0);
    check("midrst_o_empty", a_if.o_empty, 0);
    check("midrst_o_ready", a_if.o_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // 0x24 = bits 5 and 2 -> indices 2 and 5.
    exp_q_a.push_back(beat_w(2, 0, 0));
    exp_q_a.push_back(beat_w(5, 1, 0));
    send_a(8'h24, waits);
    wait_drain("after_rst");

    // LSB-first 1010_0001: indices 0, 5, 7.
    exp_q_b.push_back(beat_w(0, 0, 0));
    exp_q_b.push_back(beat_w(5, 0, 0));
    exp_q_b.push_back(beat_w(7, 1, 0));
    send_b(8'b1010_0001);
    wait_drain("lsb_a1");

    // N=16 MSB-first 0x8000: single beat index 0, last.
    exp_q_c.push_back(beat_w(0, 1, 0));
    send_c(16'h8000);
    wait_drain("n16");

    check("final_q_a", 16'(exp_q_a.size()), 0);
    check("final_q_b", 16'(exp_q_b.size()), 0);
    check("final_q_c", 16'(exp_q_c.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
